// File: rtl/arithm_issue_if.sv
// Operand/result bundle between the issue controller and its producer/consumer,
// including the side that drives and observes the arithm datapath.
interface arithm_issue_if;
  logic        in_valid;
  logic        in_ready;
  logic [13:0] in_a;
  logic [13:0] in_b;
  logic [13:0] in_c;
  logic        ar_ce;
  logic [13:0] ar_a;
  logic [13:0] ar_b;
  logic [13:0] ar_c;
  logic [28:0] ar_o;
  logic        out_valid;
  logic        out_ready;
  logic [28:0] out_full;
  logic [13:0] out_q;
  logic        out_sat;
  logic        busy;

  modport slave (
    input  in_valid, in_a, in_b, in_c, ar_o, out_ready,
    output in_ready, ar_ce, ar_a, ar_b, ar_c, out_valid, out_full, out_q, out_sat, busy
  );

  modport master (
    output in_valid, in_a, in_b, in_c, ar_o, out_ready,
    input  in_ready, ar_ce, ar_a, ar_b, ar_c, out_valid, out_full, out_q, out_sat, busy
  );
endinterface

// File: rtl/arithm_issue.sv
// Feeds operand triples from a small FWFT FIFO into the ce-gated arithm pipeline,
// tracks in-flight ops with a tag shift register and returns each O, requantised.
module arithm_issue #(
  parameter int FIFO_DEPTH = 4,
  parameter int LATENCY    = 3
) (
  input  logic           clk,
  input  logic           rst,
  arithm_issue_if.slave  io
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;

  logic [41:0]        mem [FIFO_DEPTH];
  logic [AW-1:0]      wr_ptr_reg;
  logic [AW-1:0]      rd_ptr_reg;
  logic [CW-1:0]      count_reg;
  logic [CW-1:0]      count_next;
  logic               in_ready_reg;
  logic [LATENCY-1:0] vld_reg;
  logic [LATENCY:0]   vld_shift;
  logic [13:0]        last_a_reg;
  logic [13:0]        last_b_reg;
  logic [13:0]        last_c_reg;
  logic               out_valid_reg;
  logic [28:0]        out_full_reg;
  logic [13:0]        out_q_reg;
  logic               out_sat_reg;

  logic               not_empty;
  logic               adv;
  logic               ce;
  logic               push;
  logic               pop;
  logic               capture;
  logic [41:0]        head;
  logic signed [29:0] rnd;
  logic signed [17:0] t;
  logic [13:0]        q_next;
  logic               sat_next;

  always_comb begin
    not_empty  = (count_reg != '0);
    adv        = !out_valid_reg || io.out_ready;
    // ce is held low during reset so arithm never advances on discarded ops
    ce         = adv && !rst;
    push       = io.in_valid && in_ready_reg;
    pop        = ce && not_empty;
    capture    = ce && vld_reg[LATENCY-1];
    head       = mem[rd_ptr_reg];
    count_next = count_reg + CW'(push) - CW'(pop);
    vld_shift  = {vld_reg, pop};
  end

  // Round half-up to Q2.12, then clip to the 14-bit signed range.
  always_comb begin
    rnd      = $signed({io.ar_o[28], io.ar_o}) + 30'sd2048;
    t        = rnd[29:12];
    q_next   = t[13:0];
    sat_next = 1'b0;
    if (t > 18'sd8191) begin
      q_next   = 14'h1FFF;
      sat_next = 1'b1;
    end else if (t < -18'sd8192) begin
      q_next   = 14'h2000;
      sat_next = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr_reg] <= {io.in_a, io.in_b, io.in_c};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_reg    <= '0;
      rd_ptr_reg    <= '0;
      count_reg     <= '0;
      in_ready_reg  <= 1'b1;
      vld_reg       <= '0;
      last_a_reg    <= '0;
      last_b_reg    <= '0;
      last_c_reg    <= '0;
      out_valid_reg <= 1'b0;
      out_full_reg  <= '0;
      out_q_reg     <= '0;
      out_sat_reg   <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr_reg <= wr_ptr_reg + 1'b1;
      end
      if (pop) begin
        rd_ptr_reg <= rd_ptr_reg + 1'b1;
        last_a_reg <= head[41:28];
        last_b_reg <= head[27:14];
        last_c_reg <= head[13:0];
      end
      count_reg    <= count_next;
      in_ready_reg <= (count_next != CW'(FIFO_DEPTH));
      if (ce) begin
        vld_reg <= vld_shift[LATENCY-1:0];
      end
      if (capture) begin
        out_valid_reg <= 1'b1;
        out_full_reg  <= io.ar_o;
        out_q_reg     <= q_next;
        out_sat_reg   <= sat_next;
      end else if (out_valid_reg && io.out_ready) begin
        out_valid_reg <= 1'b0;
      end
    end
  end

  // FWFT: the head is visible on ar_* while present; otherwise the last issued op holds.
  assign io.in_ready  = in_ready_reg;
  assign io.ar_ce     = ce;
  assign io.ar_a      = not_empty ? head[41:28] : last_a_reg;
  assign io.ar_b      = not_empty ? head[27:14] : last_b_reg;
  assign io.ar_c      = not_empty ? head[13:0]  : last_c_reg;
  assign io.out_valid = out_valid_reg;
  assign io.out_full  = out_full_reg;
  assign io.out_q     = out_q_reg;
  assign io.out_sat   = out_sat_reg;
  assign io.busy      = not_empty || (|vld_reg) || out_valid_reg;
endmodule

// File: tb/tb_arithm_issue.sv
// Scoreboard bench for arithm_issue with a behavioural arithm model O=(A+B)*C
// sitting behind LATENCY ce-gated stages.
module tb_arithm_issue;
  localparam int FIFO_DEPTH = 4;
  localparam int LATENCY    = 3;

  typedef struct {
    longint full;
    longint q;
    bit     sat;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   errors = 0;
  int   checks = 0;
  int   txn = 0;
  exp_t sb[$];

  arithm_issue_if bus ();

  arithm_issue #(.FIFO_DEPTH(FIFO_DEPTH), .LATENCY(LATENCY)) dut (
    .clk (clk),
    .rst (rst),
    .io  (bus)
  );

  always #5 clk = ~clk;

  // Behavioural arithm datapath
  logic signed [28:0] stg [LATENCY];
  logic signed [14:0] sum;
  logic signed [28:0] prod;
  always_comb begin
    sum  = 15'($signed(bus.ar_a)) + 15'($signed(bus.ar_b));
    prod = 29'(sum) * 29'($signed(bus.ar_c));
  end
  always @(posedge clk) begin
    if (bus.ar_ce) begin
      stg[0] <= prod;
      for (int i = 1; i < LATENCY; i++) stg[i] <= stg[i-1];
    end
  end
  assign bus.ar_o = stg[LATENCY-1];

  function automatic void check(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endfunction

  function automatic exp_t model(input int a, input int b, input int c);
    exp_t   e;
    longint t;
    e.full = longint'(a + b) * longint'(c);
    t = (e.full + 2048) >>> 12;
    if (t > 8191) begin
      e.q = 8191; e.sat = 1'b1;
    end else if (t < -8192) begin
      e.q = -8192; e.sat = 1'b1;
    end else begin
      e.q = t; e.sat = 1'b0;
    end
    return e;
  endfunction

  function automatic int rnd14();
    return int'($urandom_range(0, 16383)) - 8192;
  endfunction

  // Result monitor: a transfer happens at the next rising edge
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst && bus.out_valid && bus.out_ready) begin
        if (sb.size() == 0) begin
          check("unexpected_result", 1, 0);
        end else begin
          e = sb.pop_front();
          txn++;
          $display("txn %0d: full=%0d q=%0d sat=%0d (exp full=%0d q=%0d sat=%0d)", txn,
                   $signed(bus.out_full), $signed(bus.out_q), bus.out_sat, e.full, e.q, e.sat);
          check("out_full", longint'($signed(bus.out_full)), e.full);
          check("out_q", longint'($signed(bus.out_q)), e.q);
          check("out_sat", longint'(bus.out_sat), longint'(e.sat));
        end
      end
    end
  end

  // While a result is held without a consumer, arithm must be frozen
  always @(negedge clk) begin
    if (!rst && bus.out_valid && !bus.out_ready) check("ar_ce_stall", longint'(bus.ar_ce), 0);
  end

  // Called just after a rising edge; returns just after the accepting edge.
  task automatic push(input int a, input int b, input int c, input bit expect_ready);
    bit ok = 1'b0;
    bus.in_valid = 1'b1;
    bus.in_a = a[13:0];
    bus.in_b = b[13:0];
    bus.in_c = c[13:0];
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (expect_ready && i == 0) check("in_ready_open", longint'(bus.in_ready), 1);
      if (bus.in_ready) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) check("push_timeout", 0, 1);
    @(posedge clk);
    if (ok) sb.push_back(model(a, b, c));
    #1 bus.in_valid = 1'b0;
  endtask

  task automatic expect_out(input longint full, input longint q, input longint sat);
    bit seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (bus.out_valid) begin
        seen = 1'b1;
        break;
      end
    end
    check("result_seen", longint'(seen), 1);
    check("const_full", longint'($signed(bus.out_full)), full);
    check("const_q", longint'($signed(bus.out_q)), q);
    check("const_sat", longint'(bus.out_sat), sat);
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    for (int i = 0; i < 200; i++) begin
      if (sb.size() == 0) break;
      @(posedge clk);
    end
    #1;
    check("drain_left", longint'(sb.size()), 0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_in_ready"}, longint'(bus.in_ready), 1);
    check({tag, "_out_valid"}, longint'(bus.out_valid), 0);
    check({tag, "_out_full"}, longint'(bus.out_full), 0);
    check({tag, "_out_q"}, longint'(bus.out_q), 0);
    check({tag, "_out_sat"}, longint'(bus.out_sat), 0);
    check({tag, "_busy"}, longint'(bus.busy), 0);
    check({tag, "_ar_abc"}, longint'({bus.ar_a, bus.ar_b, bus.ar_c}), 0);
  endtask

  initial begin
    int cycles;
    bus.in_valid  = 1'b0;
    bus.in_a      = '0;
    bus.in_b      = '0;
    bus.in_c      = '0;
    bus.out_ready = 1'b1;

    // Reset
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_ar_ce", longint'(bus.ar_ce), 0);
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check_reset_outputs("rst");
    @(posedge clk);
    #1;

    // Single op: latency and exact values
    push(1325, -3225, 2316, 1'b1);
    cycles = 0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk);
      cycles++;
      @(negedge clk);
      if (bus.out_valid) break;
    end
    check("single_latency", cycles, LATENCY + 1);
    check("single_full", longint'($signed(bus.out_full)), -4400400);
    check("single_q", longint'($signed(bus.out_q)), -1074);
    check("single_sat", longint'(bus.out_sat), 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("single_busy", longint'(bus.busy), 0);
    @(posedge clk);
    #1;

    // Saturation and rounding boundaries
    push(8191, 8191, 8191, 1'b1);
    expect_out(134184962, 8191, 1);
    push(-8192, -8192, 8191, 1'b1);
    expect_out(-134201344, -8192, 1);
    push(1, 0, 2048, 1'b1);
    expect_out(2048, 1, 0);
    push(1, 0, -2049, 1'b1);
    expect_out(-2049, -1, 0);
    drain();

    // Streaming: 16 back-to-back random ops, results continuous
    fork
      begin
        bit seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
          @(negedge clk);
          if (bus.out_valid) begin
            seen = 1'b1;
            break;
          end
        end
        check("stream_first", longint'(seen), 1);
        for (int k = 0; k < 15; k++) begin
          @(negedge clk);
          check("stream_cont", longint'(bus.out_valid), 1);
        end
        @(negedge clk);
        check("stream_end", longint'(bus.out_valid), 0);
      end
      begin
        for (int k = 0; k < 16; k++) push(rnd14(), rnd14(), rnd14(), 1'b1);
      end
    join
    @(posedge clk);
    #1;
    drain();

    // Backpressure: 1 held + LATENCY in flight + FIFO_DEPTH buffered
    bus.out_ready = 1'b0;
    for (int k = 0; k < 1 + LATENCY + FIFO_DEPTH; k++) push(rnd14(), rnd14(), rnd14(), 1'b1);
    @(negedge clk);
    check("bp_in_ready_low", longint'(bus.in_ready), 0);
    check("bp_out_valid", longint'(bus.out_valid), 1);
    check("bp_busy", longint'(bus.busy), 1);
    repeat (2) @(posedge clk);
    #1 bus.out_ready = 1'b1;
    drain();

    // Reset mid-run with ops buffered/in flight
    for (int k = 0; k < 3; k++) push(rnd14(), rnd14(), rnd14(), 1'b1);
    rst = 1'b1;
    @(negedge clk);
    check("midrst_ar_ce", longint'(bus.ar_ce), 0);
    @(posedge clk);
    #1;
    sb.delete();
    rst = 1'b0;
    @(negedge clk);
    check_reset_outputs("midrst");
    repeat (10) @(posedge clk);
    #1;
    check("midrst_quiet", longint'(bus.out_valid), 0);
    push(rnd14(), rnd14(), rnd14(), 1'b1);
    drain();
    repeat (3) @(posedge clk);
    #1;
    check("final_busy", longint'(bus.busy), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
